cnn_top: RTL and testbench

- Top-level video path of the CNN board design, single clock domain.
- Configures an OV7725 camera over a write-only SCCB master.
- Captures RGB565 camera pixels into an on-chip frame buffer.
- Drives a parallel RGB LCD with generated sync/DE timing, showing the buffer at the top-left of the screen and black elsewhere.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/sccb_cfg.sv | 103 ++++++++++
 rtl/cnn_top.sv | 190 +++++++++++++++++++
 tb/tb_cnn_top.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and camera configuration table for the CNN board video path.
package cnn_pkg;

  typedef logic [15:0] rgb565_t;

  localparam logic [7:0] SCCB_ID   = 8'h42;
  localparam int         CFG_NUM   = 4;
  localparam int         SCCB_BITS = 27;

  // {addr,data} entries; element 0 (rightmost) is sent first.
  localparam logic [CFG_NUM-1:0][15:0] CFG_TABLE = {
    16'h1101, 16'h0C00, 16'h1206, 16'h1280
  };

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE
  } sccb_state_t;

  // Three bytes, each followed by a released (high) ninth bit, MSB first.
  function automatic logic [SCCB_BITS-1:0] sccb_frame(input logic [15:0] entry);
    return {SCCB_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/sccb_cfg.sv
// Write-only SCCB master that walks CFG_TABLE once after reset, then idles high.
module sccb_cfg
  import cnn_pkg::*;
#(
  parameter int SCL_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic scl_o,
  output logic sda_o
);

  localparam int DW = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam int IW = (CFG_NUM > 1) ? $clog2(CFG_NUM) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCL_DIV - 1);

  sccb_state_t           state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [1:0]            qph_q, qph_d;
  logic [4:0]            bit_q, bit_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  scl_q, scl_d, sda_q, sda_d;
  logic                  tick, qlast;
  logic [SCCB_BITS-1:0]  frame;

  assign tick  = (div_q == DIV_LAST);
  assign qlast = tick && (qph_q == 2'd3);
  assign frame = sccb_frame(CFG_TABLE[idx_q]);
  assign scl_o = scl_q;
  assign sda_o = sda_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qph_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qph_q   <= qph_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    qph_d   = '0;
    bit_d   = bit_q;
    idx_d   = idx_q;
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    if (state_q != S_IDLE && state_q != S_DONE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      qph_d = tick ? qph_q + 1'b1 : qph_q;
    end
    case (state_q)
      S_IDLE:  state_d = S_START;
      S_START: begin
        // SDA drops in quarter 1 while SCL is still high.
        scl_d = ~qph_q[1];
        sda_d = (qph_q == 2'd0);
        if (qlast) begin
          state_d = S_BIT;
          bit_d   = '0;
        end
      end
      S_BIT: begin
        scl_d = qph_q[0] ^ qph_q[1];
        sda_d = frame[5'(SCCB_BITS - 1) - bit_q];
        if (qlast) begin
          if (bit_q == 5'(SCCB_BITS - 1)) state_d = S_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        scl_d = (qph_q != 2'd0);
        sda_d = qph_q[1];
        if (qlast) state_d = S_GAP;
      end
      S_GAP: begin
        if (qlast) begin
          if (idx_q == IW'(CFG_NUM - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/cnn_top.sv
// Camera capture into an on-chip frame buffer, shown top-left on a parallel RGB LCD.
module cnn_top
  import cnn_pkg::*;
#(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2,
  parameter int FB_W    = 64,
  parameter int FB_H    = 48,
  parameter int SCL_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_rgb,
  output logic        o_rgb_clk,
  output logic        lcd_de,
  output logic        lcd_rst_n,
  output logic        lcd_bl,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        ova_cfg_scl,
  output logic        ova_cfg_sda,
  input  logic        i_pclk,
  input  logic [7:0]  i_data,
  input  logic        href,
  input  logic        vsync
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int FB_AW   = $clog2(FB_W * FB_H);
  localparam int CXW     = $clog2(FB_W + 1);
  localparam int CYW     = $clog2(FB_H + 1);

  localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  HS_END = HW'(H_SYNC);
  localparam logic [HW-1:0]  HA_BEG = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0]  HA_END = HW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [HW-1:0]  FBW_H  = HW'(FB_W);
  localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  VS_END = VW'(V_SYNC);
  localparam logic [VW-1:0]  VA_BEG = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0]  VA_END = VW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [VW-1:0]  FBH_V  = VW'(FB_H);
  localparam logic [CXW-1:0] FBW_C  = CXW'(FB_W);
  localparam logic [CYW-1:0] FBH_C  = CYW'(FB_H);

  rgb565_t fb [FB_W * FB_H];

  sccb_cfg #(.SCL_DIV(SCL_DIV)) u_sccb (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .scl_o  (ova_cfg_scl),
    .sda_o  (ova_cfg_sda)
  );

  // ---- capture: synchronise camera bus into clk ----
  logic       pclk_s1_q, pclk_s2_q, href_s1_q, href_s2_q, href_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0] data_s1_q, data_s2_q, hi_q, hi_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic       ph_q, ph_d, wr_en;
  logic [FB_AW-1:0] wr_addr;
  rgb565_t    wr_data;

  always_ff @(posedge clk) begin
    data_s1_q <= i_data;
    data_s2_q <= data_s1_q;
    hi_q      <= hi_d;
    if (!rst_n) begin
      {pclk_s1_q, pclk_s2_q} <= '0;
      {href_s1_q, href_s2_q, href_s3_q} <= '0;
      {vs_s1_q, vs_s2_q, vs_s3_q} <= '0;
      cx_q <= '0;
      cy_q <= '0;
      ph_q <= 1'b0;
    end else begin
      {pclk_s1_q, pclk_s2_q} <= {i_pclk, pclk_s1_q};
      {href_s1_q, href_s2_q, href_s3_q} <= {href, href_s1_q, href_s2_q};
      {vs_s1_q, vs_s2_q, vs_s3_q} <= {vsync, vs_s1_q, vs_s2_q};
      cx_q <= cx_d;
      cy_q <= cy_d;
      ph_q <= ph_d;
    end
  end

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    wr_en   = 1'b0;
    wr_data = {hi_q, data_s2_q};
    wr_addr = FB_AW'(cy_q) * FB_AW'(FB_W) + FB_AW'(cx_q);
    if (vs_s2_q && !vs_s3_q) begin
      cx_d = '0;
      cy_d = '0;
      ph_d = 1'b0;
    end else if (!href_s2_q && href_s3_q) begin
      cx_d = '0;
      ph_d = 1'b0;
      if (cy_q < FBH_C) cy_d = cy_q + 1'b1;
    end else if (pclk_s1_q && !pclk_s2_q && href_s2_q) begin
      ph_d = ~ph_q;
      if (!ph_q) begin
        hi_d = data_s2_q;
      end else begin
        // Pixels beyond the buffer are dropped; cx saturates so nothing wraps.
        wr_en = (cx_q < FBW_C) && (cy_q < FBH_C);
        if (cx_q < FBW_C) cx_d = cx_q + 1'b1;
      end
    end
  end

  // ---- LCD p0: raster counters and buffer read address ----
  logic          rgb_clk_q, lcd_rst_q, lcd_bl_q, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [HW-1:0] hcnt_q, hcnt_d, x_p0;
  logic [VW-1:0] vcnt_q, vcnt_d, y_p0;
  logic          fb_win;
  logic [FB_AW-1:0] rd_addr;
  rgb565_t       rd_p1_q, rgb_q, rgb_d;

  always_comb begin
    hcnt_d  = hcnt_q + 1'b1;
    vcnt_d  = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
    hs_d    = (hcnt_q >= HS_END);
    vs_d    = (vcnt_q >= VS_END);
    de_d    = (hcnt_q >= HA_BEG) && (hcnt_q < HA_END) &&
              (vcnt_q >= VA_BEG) && (vcnt_q < VA_END);
    x_p0    = hcnt_q - HA_BEG;
    y_p0    = vcnt_q - VA_BEG;
    fb_win  = de_d && (x_p0 < FBW_H) && (y_p0 < FBH_V);
    rd_addr = FB_AW'(y_p0) * FB_AW'(FB_W) + FB_AW'(x_p0);
    rgb_d   = fb_win ? rd_p1_q : '0;
  end

  // ---- buffer p1: one write port, one registered read port (old data on collision) ----
  always_ff @(posedge clk) begin
    if (wr_en) fb[wr_addr] <= wr_data;
    rd_p1_q <= fb[rd_addr];
  end

  // ---- LCD p2: sync, DE and pixel registered together on the falling pixel clock ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_clk_q <= 1'b0;
      lcd_rst_q <= 1'b0;
      lcd_bl_q  <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      rgb_clk_q <= ~rgb_clk_q;
      lcd_rst_q <= 1'b1;
      lcd_bl_q  <= 1'b1;
      if (rgb_clk_q) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        de_q   <= de_d;
        rgb_q  <= rgb_d;
      end
    end
  end

  assign o_rgb     = rgb_q;
  assign o_rgb_clk = rgb_clk_q;
  assign lcd_de    = de_q;
  assign lcd_hs    = hs_q;
  assign lcd_vs    = vs_q;
  assign lcd_rst_n = lcd_rst_q;
  assign lcd_bl    = lcd_bl_q;

endmodule

// File: tb/tb_cnn_top.sv
// Scoreboard bench for cnn_top: SCCB frames, LCD raster timing and captured pixels.
module tb_cnn_top;

  localparam int H_SYNC = 4, H_BACK = 2, H_DISP = 104, H_FRONT = 2;
  localparam int V_SYNC = 2, V_BACK = 2, V_DISP = 50,  V_FRONT = 2;
  localparam int FB_W = 64, FB_H = 48, SCL_DIV = 4;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA_BEG = H_SYNC + H_BACK, VA_BEG = V_SYNC + V_BACK;
  localparam int FRAME_CLK = H_TOTAL * V_TOTAL * 2;

  logic        clk = 1'b0, rst_n, i_pclk, href, vsync;
  logic [7:0]  i_data;
  logic [15:0] o_rgb;
  logic        o_rgb_clk, lcd_de, lcd_rst_n, lcd_bl, lcd_hs, lcd_vs, ova_cfg_scl, ova_cfg_sda;

  cnn_top #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
    .FB_W(FB_W), .FB_H(FB_H), .SCL_DIV(SCL_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_rgb(o_rgb), .o_rgb_clk(o_rgb_clk), .lcd_de(lcd_de),
    .lcd_rst_n(lcd_rst_n), .lcd_bl(lcd_bl), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .ova_cfg_scl(ova_cfg_scl), .ova_cfg_sda(ova_cfg_sda), .i_pclk(i_pclk),
    .i_data(i_data), .href(href), .vsync(vsync)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; logic [15:0] v; } px_t;
  px_t         px_q[$];
  logic [26:0] sccb_q[$];
  int n_vec = 0, n_err = 0;
  int frame_cnt = 0, sccb_n = 0;
  bit mon_en = 0, armed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_px(input int x, input int y, input logic [15:0] v);
    px_t e;
    e.x = x; e.y = y; e.v = v;
    px_q.push_back(e);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    i_data = b;
    repeat (2) @(negedge clk);
    i_pclk = 1'b1;
    repeat (4) @(negedge clk);
    i_pclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cam_pix(input logic [15:0] p);
    cam_byte(p[15:8]);
    cam_byte(p[7:0]);
  endtask

  task automatic cam_href(input logic lvl);
    href = lvl;
    repeat (6) @(negedge clk);
  endtask

  task automatic cam_vsync();
    vsync = 1'b1;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Arm the pixel scoreboard for the next whole LCD frame and drain it.
  task automatic run_frame_check(input string tag);
    int fc0;
    bit seen;
    fc0  = frame_cnt;
    seen = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !seen; i++) begin
      @(negedge clk);
      seen = (frame_cnt != fc0);
    end
    check_val({tag, "_frame_start"}, seen, 1);
    armed = 1;
    for (int i = 0; i < FRAME_CLK + 100 && px_q.size() > 0; i++) @(negedge clk);
    armed = 0;
    check_val({tag, "_px_pending"}, px_q.size(), 0);
    px_q.delete();
  endtask

  // LCD raster monitor: one sample per pixel tick, right after the outputs update.
  initial begin
    bit prev_hs = 1, prev_vs = 1, line_ok = 0, frame_ok = 0, vs_line = 0;
    bit hs_fall, vs_fall;
    int tpos = 0, lpos = 0, hs_low = 0, de_cnt = 0, vs_lines = 0, de_lines = 0, leak = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !o_rgb_clk) begin
        hs_fall = prev_hs && !lcd_hs;
        vs_fall = prev_vs && !lcd_vs;
        if (hs_fall) begin
          if (line_ok && frame_ok) begin
            check_val("hs_low_ticks", hs_low, H_SYNC);
            check_val("line_ticks", tpos, H_TOTAL);
            check_val($sformatf("de_ticks_line%0d", lpos), de_cnt,
                      (lpos >= VA_BEG && lpos < VA_BEG + V_DISP) ? H_DISP : 0);
            if (de_cnt == H_DISP) de_lines++;
            if (vs_line) vs_lines++;
          end
          if (vs_fall) begin
            if (frame_ok) begin
              check_val("vs_low_lines", vs_lines, V_SYNC);
              check_val("de_lines", de_lines, V_DISP);
              check_val("frame_lines", lpos + 1, V_TOTAL);
              check_val("rgb_outside_de", leak, 0);
            end
            frame_ok = 1; lpos = 0; vs_lines = 0; de_lines = 0; leak = 0;
            frame_cnt++;
          end else begin
            lpos++;
          end
          line_ok = 1; tpos = 0; hs_low = 0; de_cnt = 0; vs_line = !lcd_vs;
        end
        if (armed && frame_ok && px_q.size() > 0 &&
            tpos - HA_BEG == px_q[0].x && lpos - VA_BEG == px_q[0].y) begin
          check_val($sformatf("px(%0d,%0d)", px_q[0].x, px_q[0].y), o_rgb, px_q[0].v);
          check_val($sformatf("px_de(%0d,%0d)", px_q[0].x, px_q[0].y), lcd_de, 1);
          void'(px_q.pop_front());
        end
        if (!lcd_hs) hs_low++;
        if (lcd_de) de_cnt++;
        if (!lcd_de && o_rgb != 16'h0) leak++;
        tpos++;
        prev_hs = lcd_hs;
        prev_vs = lcd_vs;
      end
    end
  end

  // SCCB monitor: START/STOP framing and bits sampled on SCL rising edges.
  initial begin
    bit p_scl = 1, p_sda = 1, in_tr = 0;
    logic [31:0] bits = '0;
    int nb = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_scl && ova_cfg_scl && p_sda && !ova_cfg_sda) begin
          in_tr = 1; nb = 0; bits = '0;
        end else if (in_tr && p_scl && ova_cfg_scl && !p_sda && ova_cfg_sda) begin
          in_tr = 0;
          // The STOP setup also raises SCL once with SDA low: 27 data bits + 1.
          check_val("sccb_bitcount", nb, 28);
          if (sccb_q.size() == 0) check_val("sccb_extra_frame", 1, 0);
          else check_val($sformatf("sccb_frame%0d", sccb_n), bits[27:1], sccb_q.pop_front());
          sccb_n++;
        end else if (in_tr && !p_scl && ova_cfg_scl) begin
          bits = {bits[30:0], ova_cfg_sda};
          nb++;
        end
        p_scl = ova_cfg_scl;
        p_sda = ova_cfg_sda;
      end
    end
  end

  initial begin
    int bad;
    rst_n = 1'b0; i_pclk = 1'b0; i_data = 8'h00; href = 1'b0; vsync = 1'b0;
    sccb_q.push_back({8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1});
    sccb_q.push_back({8'h42, 1'b1, 8'h12, 1'b1, 8'h06, 1'b1});
    sccb_q.push_back({8'h42, 1'b1, 8'h0C, 1'b1, 8'h00, 1'b1});
    sccb_q.push_back({8'h42, 1'b1, 8'h11, 1'b1, 8'h01, 1'b1});
    repeat (5) @(negedge clk);
    check_val("rst_rgb", o_rgb, 0);
    check_val("rst_rgb_clk", o_rgb_clk, 0);
    check_val("rst_de", lcd_de, 0);
    check_val("rst_hs", lcd_hs, 1);
    check_val("rst_vs", lcd_vs, 1);
    check_val("rst_lcd_rst_n", lcd_rst_n, 0);
    check_val("rst_bl", lcd_bl, 0);
    check_val("rst_scl", ova_cfg_scl, 1);
    check_val("rst_sda", ova_cfg_sda, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_lcd_rst_n", lcd_rst_n, 1);
    check_val("rel_bl", lcd_bl, 1);
    mon_en = 1;

    // Frame A: two pixels on row 0, one on row 1.
    cam_vsync();
    cam_href(1);
    cam_pix(16'hF800);
    cam_pix(16'h07E0);
    cam_href(0);
    cam_href(1);
    cam_pix(16'h1234);
    cam_href(0);
    expect_px(0, 0, 16'hF800);
    expect_px(1, 0, 16'h07E0);
    expect_px(64, 0, 16'h0000);
    expect_px(0, 1, 16'h1234);
    expect_px(100, 10, 16'h0000);
    expect_px(0, 48, 16'h0000);
    run_frame_check("frameA");

    // Frame B: an overlong row 0; the surplus must not spill into row 1.
    cam_vsync();
    cam_href(1);
    for (int k = 0; k < 70; k++) cam_pix(16'hA000 + 16'(k));
    cam_href(0);
    expect_px(0, 0, 16'hA000);
    expect_px(1, 0, 16'hA001);
    expect_px(63, 0, 16'hA03F);
    expect_px(64, 0, 16'h0000);
    expect_px(0, 1, 16'h1234);
    run_frame_check("frameB_row0");

    cam_href(1);
    cam_pix(16'h5555);
    cam_pix(16'h5AAA);
    cam_href(0);
    expect_px(0, 0, 16'hA000);
    expect_px(0, 1, 16'h5555);
    expect_px(1, 1, 16'h5AAA);
    run_frame_check("frameB_row1");

    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ova_cfg_scl !== 1'b1 || ova_cfg_sda !== 1'b1) bad++;
    end
    check_val("sccb_done_idle", bad, 0);
    check_val("sccb_frames", sccb_n, 4);

    mon_en = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("midrst_rgb", o_rgb, 0);
    check_val("midrst_rgb_clk", o_rgb_clk, 0);
    check_val("midrst_de", lcd_de, 0);
    check_val("midrst_hs", lcd_hs, 1);
    check_val("midrst_vs", lcd_vs, 1);
    check_val("midrst_bl", lcd_bl, 0);
    check_val("midrst_scl", ova_cfg_scl, 1);
    check_val("midrst_sda", ova_cfg_sda, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
